// File: rtl/ysyx_22050612_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_mem_pkg
// Brief    : Shared types and constants for the instruction-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050612_mem_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // Default byte address of word 0 (reset PC of the NPC)
  localparam logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000;

  // Instruction word width
  localparam int INST_W = 32;

endpackage : ysyx_22050612_mem_pkg
`default_nettype wire

// File: rtl/ysyx_22050612_imem_array.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_imem_array
// Brief    : DEPTH x 32-bit instruction storage. One synchronous read port
//            with a registered output and one write port. A read and a write
//            to the same index on the same edge return the old contents.
//            Storage is not reset; only the read-data register is.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_imem_array
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  // read port
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [INST_W-1:0]          rdata_o,
  // write port
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [INST_W-1:0]          wdata_i
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rdata_q;

  // Read register: cleared by reset, loaded only on an enabled read so the
  // word stays put while the responder holds its answer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  // Storage write; non-blocking update gives read-before-write ordering.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule : ysyx_22050612_imem_array
`default_nettype wire

// File: rtl/ysyx_22050612_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_imem_resp
// Brief    : Memory-side end of the IFU fetch interface. Accepts one fetch PC
//            on the request channel, waits LAT cycles and returns the
//            instruction word plus an error flag on the response channel.
//            A loader write port preloads the program image.
//            Optional macro YSYX_22050612_IMEM_CHK_EN enables alignment and
//            range checking; without it rsp_err is 0 and the index wraps.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_imem_resp
  import ysyx_22050612_mem_pkg::*;
#(
  parameter logic [63:0] BASE  = IMEM_BASE,
  parameter int          DEPTH = 4096,
  parameter int          LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  // fetch request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  // fetch response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INST_W-1:0] rsp_inst,
  output logic              rsp_err,
  // loader write port
  input  logic              wr_en,
  input  logic [63:0]       wr_addr,
  input  logic [INST_W-1:0] wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LAT + 1);
  // WAIT lasts LAT-1 cycles; the counter counts down to zero inclusive.
  localparam logic [CNT_W-1:0] C_CNT_INIT = (LAT >= 2) ? CNT_W'(LAT - 2) : '0;

  imem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              err_q,   err_d;

  logic              w_accept;
  logic              w_err;
  logic [IDX_W+1:0]  w_rd_off;
  logic [IDX_W+1:0]  w_wr_off;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [INST_W-1:0] w_rdata;
  logic              w_unused_addr;

  // Word index = (addr - BASE) >> 2, truncated. Only the low IDX_W+2 bits of
  // the difference matter after truncation, so the subtract is kept narrow.
  assign w_rd_off = req_addr[IDX_W+1:0] - BASE[IDX_W+1:0];
  assign w_wr_off = wr_addr[IDX_W+1:0]  - BASE[IDX_W+1:0];
  assign w_rd_idx = w_rd_off[IDX_W+1:2];
  assign w_wr_idx = w_wr_off[IDX_W+1:2];

  // Address bits that do not reach the index when range checks are off.
  assign w_unused_addr = ^{req_addr[63:IDX_W+2], wr_addr[63:IDX_W+2],
                           w_rd_off[1:0], w_wr_off[1:0]};

`ifdef YSYX_22050612_IMEM_CHK_EN
  localparam logic [63:0] C_LIMIT = BASE + (64'(DEPTH) << 2);

  // Misaligned, below BASE, or past the last word.
  assign w_err = (req_addr[1:0] != 2'b00) ||
                 (req_addr < BASE)        ||
                 (req_addr >= C_LIMIT);
`else
  assign w_err = 1'b0;
`endif

  // State, latency counter and latched error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    w_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          err_d    = w_err;
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = C_CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Faulting fetches never touch the array; their word is forced to zero.
  ysyx_22050612_imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .re_i    (w_accept && !w_err),
    .raddr_i (w_rd_idx),
    .rdata_o (w_rdata),
    .we_i    (wr_en),
    .waddr_i (w_wr_idx),
    .wdata_i (wr_data)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_inst  = err_q ? '0 : w_rdata;

endmodule : ysyx_22050612_imem_resp
`default_nettype wire

// File: tb/tb_ysyx_22050612_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050612_imem_resp
// Brief    : Self-checking bench for the instruction-memory responder. Three
//            responders (LAT = 1, 2, 3) share clock, reset, loader port and
//            response ready; each has its own request valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_imem_resp;
  import ysyx_22050612_mem_pkg::*;

  localparam logic [63:0] C_BASE  = IMEM_BASE;
  localparam int          C_DEPTH = 4096;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [63:0]      req_addr;
  logic [2:0]       rsp_valid;
  logic             rsp_ready;
  logic [2:0][31:0] rsp_inst;
  logic [2:0]       rsp_err;
  logic             wr_en;
  logic [63:0]      wr_addr;
  logic [31:0]      wr_data;

  int               checks = 0;
  int               errors = 0;
  logic [31:0]      model [int];
  exp_t             sb_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_22050612_imem_resp #(
      .BASE  (C_BASE),
      .DEPTH (C_DEPTH),
      .LAT   (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_inst  (rsp_inst[g]),
      .rsp_err   (rsp_err[g]),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int widx(logic [63:0] a);
    logic [63:0] off;
    off = a - C_BASE;
    return int'((off >> 2) & 64'(C_DEPTH - 1));
  endfunction

  // Expected response for a fetch of address a given the current image.
  function automatic exp_t exp_of(logic [63:0] a);
    exp_t e;
    e.err  = 1'b0;
    e.inst = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
`ifdef YSYX_22050612_IMEM_CHK_EN
    if (a[1:0] != 2'b00 || a < C_BASE || a >= C_BASE + 64'(C_DEPTH * 4)) begin
      e.inst = 32'h0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic load(int idx, logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = C_BASE + 64'(idx * 4);
    wr_data = data;
    step();
    wr_en   = 1'b0;
    model[idx] = data;
  endtask

  // One fetch on responder d (LAT = d+1). hold = cycles with rsp_ready low
  // in RESP; same_wr = loader writes DEADBEEF to the fetched word on the
  // accepting edge.
  task automatic fetch(int d, logic [63:0] a, int hold, bit same_wr);
    exp_t e;
    int   lat;
    lat = d + 1;
    chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_addr     = a;
    if (same_wr) begin
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = 32'hDEAD_BEEF;
    end
    sb_q.push_back(exp_of(a));
    step();
    req_valid[d] = 1'b0;
    wr_en        = 1'b0;
    if (same_wr) model[widx(a)] = 32'hDEAD_BEEF;
    for (int i = 1; i < lat; i++) begin
      chk("no_early_valid", 64'(rsp_valid[d]), 64'd0);
      chk("busy_not_ready", 64'(req_ready[d]), 64'd0);
      step();
    end
    chk("valid_at_lat", 64'(rsp_valid[d]), 64'd1);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(rsp_valid[d]), 64'd1);
      chk("hold_inst", 64'(rsp_inst[d]), 64'(e.inst));
      chk("hold_not_ready", 64'(req_ready[d]), 64'd0);
      if (i == 0) begin
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = 32'h0000_0113;
      end
      step();
      if (i == 0) begin
        wr_en = 1'b0;
        model[widx(a)] = 32'h0000_0113;
      end
    end
    chk("rsp_inst", 64'(rsp_inst[d]), 64'(e.inst));
    chk("rsp_err", 64'(rsp_err[d]), 64'(e.err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs_valid", 64'(rsp_valid[d]), 64'd0);
    chk("post_hs_ready", 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n_acc, n_rsp, last_acc, cyc;
    bit   acc, hs;

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    // Preload while in reset; loader writes are accepted in any state.
    load(0, 32'h0010_0093);
    load(1, 32'h0000_0073);
    for (int i = 2; i < 16; i++) load(i, 32'hA000_0000 + 32'(i));
    load(5, 32'h1111_1111);
    load(C_DEPTH - 1, 32'hCAFE_0FFF);

    for (int d = 0; d < 3; d++) chk("ready_in_rst", 64'(req_ready[d]), 64'd0);
    rst = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 64'(rsp_valid[d]), 64'd0);
      chk("rst_inst", 64'(rsp_inst[d]), 64'd0);
      chk("rst_err", 64'(rsp_err[d]), 64'd0);
      chk("rst_ready", 64'(req_ready[d]), 64'd1);
    end

    // LAT=1 basic fetch
    fetch(0, C_BASE, 0, 1'b0);
    // LAT=3 with response held off for 5 cycles and a write to the pending word
    fetch(2, C_BASE + 64'd4, 5, 1'b0);
    // Boundary addresses: misaligned, below BASE, one past the end
    fetch(0, C_BASE + 64'd2, 0, 1'b0);
    fetch(0, C_BASE - 64'd4, 0, 1'b0);
    fetch(0, C_BASE + 64'h4000, 0, 1'b0);
    fetch(1, C_BASE + 64'h4000, 0, 1'b0);
    // Same-edge write: old data first, new data on the next fetch
    fetch(0, C_BASE + 64'd20, 0, 1'b1);
    fetch(0, C_BASE + 64'd20, 0, 1'b0);

    // Reset one cycle after accept on the LAT=2 responder
    chk("pre_rst_ready", 64'(req_ready[1]), 64'd1);
    req_valid[1] = 1'b1;
    req_addr     = C_BASE + 64'd8;
    step();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 64'(req_ready[1]), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid[1]), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", 64'(rsp_valid[1]), 64'd0);
      chk("post_rst_inst", 64'(rsp_inst[1]), 64'd0);
      chk("post_rst_err", 64'(rsp_err[1]), 64'd0);
      chk("post_rst_ready", 64'(req_ready[1]), 64'd1);
    end

    // Back-to-back: 8 sequential PCs on LAT=2, valid and ready held high
    n_acc     = 0;
    n_rsp     = 0;
    last_acc  = -1;
    cyc       = 0;
    rsp_ready = 1'b1;
    req_addr  = C_BASE;
    req_valid[1] = 1'b1;
    while (n_rsp < 8 && cyc < 200) begin
      acc = req_valid[1] && req_ready[1];
      hs  = rsp_valid[1] && rsp_ready;
      if (hs) begin
        if (sb_q.size() == 0) begin
          chk("b2b_sb_nonempty", 64'd0, 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("b2b_inst", 64'(rsp_inst[1]), 64'(e.inst));
          chk("b2b_err", 64'(rsp_err[1]), 64'(e.err));
        end
        n_rsp++;
      end
      if (acc) begin
        sb_q.push_back(exp_of(req_addr));
        if (last_acc >= 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
        n_acc++;
      end
      step();
      cyc++;
      if (acc) begin
        if (n_acc < 8) req_addr = req_addr + 64'd4;
        else req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b0;
    chk("b2b_rsp_count", 64'(n_rsp), 64'd8);
    chk("b2b_acc_count", 64'(n_acc), 64'd8);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ysyx_22050612_imem_resp
`default_nettype wire
